// File: rtl/ex_muldiv_unit_if.sv
// Handshake/operand bundle between the EX-stage issue logic and the multiply/divide unit.
interface ex_muldiv_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, src_a, src_b,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO; fixed-latency MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO.
// Optional MADD (md_op 111) is built only when MD_MADD_EN is defined.
module ex_muldiv_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    ex_muldiv_unit_if.slave  md
);
    localparam int unsigned XLEN       = 32;
    localparam int unsigned DLEN       = 2 * XLEN;
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
`ifdef MD_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b111;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   stage_hi;
    logic [XLEN-1:0]   stage_lo;
    logic              stage_upd;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;

    logic              is_mul;
    logic              is_div;
    logic              is_signed;
    logic              is_mthi;
    logic              is_mtlo;
    logic              is_multi;
`ifdef MD_MADD_EN
    logic              is_madd;
`endif

    logic              load_op;
    logic              commit;
    logic              wr_hi;
    logic              wr_lo;

    logic [DLEN-1:0]   a_sx;
    logic [DLEN-1:0]   b_sx;
    logic [DLEN-1:0]   prod_s;
    logic [DLEN-1:0]   prod_u;
    logic [XLEN-1:0]   dvd;
    logic [XLEN-1:0]   dvs;
    logic [XLEN-1:0]   q_mag;
    logic [XLEN-1:0]   r_mag;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [DLEN-1:0]   res;
    logic              res_upd;

    // Opcode decode
    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
`ifdef MD_MADD_EN
        is_madd   = 1'b0;
`endif
        case (md.md_op)
            OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            OP_MTHI:  is_mthi = 1'b1;
            OP_MTLO:  is_mtlo = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; is_signed = 1'b1; is_madd = 1'b1; end
`endif
            default:  ;
        endcase
        is_multi = is_mul | is_div;
    end

    // Result computed at the start edge; division runs on magnitudes then re-applies signs,
    // which also yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    always_comb begin
        a_sx   = {{XLEN{md.src_a[XLEN-1]}}, md.src_a};
        b_sx   = {{XLEN{md.src_b[XLEN-1]}}, md.src_b};
        prod_s = a_sx * b_sx;
        prod_u = {{XLEN{1'b0}}, md.src_a} * {{XLEN{1'b0}}, md.src_b};

        dvd = (is_signed && md.src_a[XLEN-1]) ? (~md.src_a + XLEN'(1)) : md.src_a;
        dvs = (is_signed && md.src_b[XLEN-1]) ? (~md.src_b + XLEN'(1)) : md.src_b;
        if (dvs == '0) begin
            dvs = XLEN'(1);
        end
        q_mag = dvd / dvs;
        r_mag = dvd % dvs;
        quot  = (is_signed && (md.src_a[XLEN-1] ^ md.src_b[XLEN-1])) ? (~q_mag + XLEN'(1)) : q_mag;
        rem   = (is_signed && md.src_a[XLEN-1]) ? (~r_mag + XLEN'(1)) : r_mag;

        res_upd = 1'b1;
        if (is_div) begin
            res     = {rem, quot};
            res_upd = (md.src_b != '0);
        end else if (is_signed) begin
            res = prod_s;
        end else begin
            res = prod_u;
        end
`ifdef MD_MADD_EN
        if (is_madd) begin
            res = {hi_q, lo_q} + prod_s;
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (md.start && is_multi) state_nxt = RUN;
            RUN:  if (cnt == CNT_W'(0))     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM control outputs; start during RUN is deliberately ignored
    always_comb begin
        load_op = 1'b0;
        commit  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (state)
            IDLE: begin
                load_op = md.start & is_multi;
                wr_hi   = md.start & is_mthi;
                wr_lo   = md.start & is_mtlo;
            end
            RUN:  commit = (cnt == CNT_W'(0));
            default: ;
        endcase
    end

    // Latency counter and staging registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            stage_hi  <= '0;
            stage_lo  <= '0;
            stage_upd <= 1'b0;
        end else if (load_op) begin
            cnt       <= is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            stage_hi  <= res[DLEN-1:XLEN];
            stage_lo  <= res[XLEN-1:0];
            stage_upd <= res_upd;
        end else if (state == RUN && cnt != CNT_W'(0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (wr_hi) begin
                hi_q <= md.src_a;
            end else if (commit && stage_upd) begin
                hi_q <= stage_hi;
            end
            if (wr_lo) begin
                lo_q <= md.src_a;
            end else if (commit && stage_upd) begin
                lo_q <= stage_lo;
            end
        end
    end

    assign md.busy     = (state == RUN);
    assign md.md_stall = md.start | md.busy;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: arithmetic reference model plus directed literal checks.
module tb_ex_muldiv_unit;
    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk;
    logic reset;
    ex_muldiv_unit_if bus ();

    ex_muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic with a pending result released after N cycles
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_upd;
    int          m_left;
    longint      sa, sb, ua, ub, q, r, prod;
    logic [63:0] tmp;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_left = 0; p_upd = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_upd) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (bus.start) begin
            sa = longint'($signed(bus.src_a));
            sb = longint'($signed(bus.src_b));
            ua = longint'({32'h0, bus.src_a});
            ub = longint'({32'h0, bus.src_b});
            case (bus.md_op)
                3'd1: begin prod = sa * sb; tmp = prod; p_upd = 1'b1; m_left = MC; end
                3'd2: begin prod = ua * ub; tmp = prod; p_upd = 1'b1; m_left = MC; end
                3'd3, 3'd4: begin
                    m_left = DC;
                    p_upd  = (bus.src_b != 0);
                    if (p_upd) begin
                        if (bus.md_op == 3'd3) begin q = sa / sb; r = sa % sb; end
                        else begin q = ua / ub; r = ua % ub; end
                        tmp = {r[31:0], q[31:0]};
                    end
                end
                3'd5: m_hi = bus.src_a;
                3'd6: m_lo = bus.src_a;
`ifdef MD_MADD_EN
                3'd7: begin prod = sa * sb; tmp = {m_hi, m_lo} + prod; p_upd = 1'b1; m_left = MC; end
`endif
                default: ;
            endcase
            p_hi = tmp[63:32];
            p_lo = tmp[31:0];
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 64'(bus.busy), 64'(m_left > 0));
            check("cyc_md_stall", 64'(bus.md_stall), 64'(bus.start | (m_left > 0)));
            check("cyc_hi", 64'(bus.hi), 64'(m_hi));
            check("cyc_lo", 64'(bus.lo), 64'(m_lo));
        end
    end

    // Issue one op at posedge+1, count busy cycles, then compare HI/LO against literals
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        bus.start = 1'b1; bus.md_op = op; bus.src_a = a; bus.src_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.md_op = 3'd0; bus.src_a = 32'hDEADBEEF; bus.src_b = 32'h0BADF00D;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
        check({name, "_busy_cycles"}, 64'(n), 64'(exp_n));
        check({name, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({name, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.start = 1'b0; bus.md_op = 3'd0; bus.src_a = '0; bus.src_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        chk_en = 1'b1;

        run_op("mult",   3'd1, 32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
        run_op("div_neg",3'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_ovf",3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        run_op("divu_z", 3'd4, 32'h00000005, 32'h00000000, 10, 32'h00000000, 32'h80000000);
        run_op("divu",   3'd4, 32'd100,      32'd7,        10, 32'd2,        32'd14);
        run_op("div_nb", 3'd3, 32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD);
        run_op("div_z",  3'd3, 32'hFFFFFFF9, 32'h00000000, 10, 32'd1,        32'hFFFFFFFD);

        // MTHI then MTLO back to back
        bus.start = 1'b1; bus.md_op = 3'd5; bus.src_a = 32'h12345678;
        @(posedge clk); #1;
        bus.md_op = 3'd6; bus.src_a = 32'h9ABCDEF0;
        @(negedge clk);
        check("mthi_hi", 64'(bus.hi), 64'h12345678);
        check("mthi_lo", 64'(bus.lo), 64'hFFFFFFFD);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.md_op = 3'd0;
        @(negedge clk);
        check("mtlo_hi", 64'(bus.hi), 64'h12345678);
        check("mtlo_lo", 64'(bus.lo), 64'h9ABCDEF0);
        check("mtlo_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;

`ifdef MD_MADD_EN
        run_op("madd_pre_hi", 3'd5, 32'h00000000, 32'h0, 0, 32'h00000000, 32'h9ABCDEF0);
        run_op("madd_pre_lo", 3'd6, 32'hFFFFFFFF, 32'h0, 0, 32'h00000000, 32'hFFFFFFFF);
        run_op("madd", 3'd7, 32'd1, 32'd1, 5, 32'h00000001, 32'h00000000);
`else
        run_op("op7_noop", 3'd7, 32'd1, 32'd1, 0, 32'h12345678, 32'h9ABCDEF0);
`endif

        // Reset asserted in the 4th busy cycle of a DIV
        bus.start = 1'b1; bus.md_op = 3'd3; bus.src_a = 32'd100; bus.src_b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.md_op = 3'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_hi", 64'(bus.hi), 64'd0);
        check("rst_mid_lo", 64'(bus.lo), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("rst_after_busy", 64'(bus.busy), 64'd0);
            check("rst_after_hilo", {bus.hi, bus.lo}, 64'd0);
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
